// File: rtl/mem_handshake_bridge_if.sv
// mem_handshake_bridge_if: req/ready bus between the bridge and a variable-latency memory
interface mem_handshake_bridge_if;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_handshake_bridge.sv
// mem_handshake_bridge: adapts the multicycle core's memory strobes to a req/ready memory,
// stalling the core until completion and flagging misaligned or timed-out accesses
module mem_handshake_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   Adr,
    input  logic [31:0]                   WriteData,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic                          ErrClear,
    output logic [31:0]                   ReadData,
    output logic                          Stall,
    output logic                          MisalignErr,
    output logic                          TimeoutErr,
    mem_handshake_bridge_if.master        mem
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic        access, misalign, timeout;
    assign access   = MemRead | MemWrite;
    assign misalign = state == IDLE && access && Adr[1:0] != 2'b00;
    // ready in the same cycle as the last allowed wait still completes normally
    assign timeout  = state == BUSY && !mem.mem_ready && cnt + 16'd1 == 16'(TIMEOUT);
    assign Stall    = state == BUSY || (state == IDLE && access);
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            ReadData      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            MisalignErr   <= 1'b0;
            TimeoutErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (access) begin
                    if (misalign) begin
                        state    <= DONE;
                        ReadData <= '0;
                    end else begin
                        state         <= BUSY;
                        cnt           <= '0;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= MemWrite;
                        mem.mem_addr  <= {Adr[31:2], 2'b00};
                        mem.mem_wdata <= WriteData;
                    end
                end
                BUSY: if (mem.mem_ready || timeout) begin
                    state       <= DONE;
                    mem.mem_req <= 1'b0;
                    if (!mem.mem_we) ReadData <= mem.mem_ready ? mem.mem_rdata : ERR_DATA;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
            MisalignErr <= misalign | (MisalignErr & ~ErrClear);
            TimeoutErr  <= timeout | (TimeoutErr & ~ErrClear);
        end
    end
endmodule

// File: tb/tb_mem_handshake_bridge.sv
// tb_mem_handshake_bridge: directed vector table, hand sequences and randomized accesses
// checked against a per-transaction model of the bridge
module tb_mem_handshake_bridge;
    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] adr, wdata, rdata;
        logic        rd, wr, clr;
        int          lat;
        int          e_stall, e_req;
        logic [31:0] e_rdata;
        logic        e_mis, e_tmo;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] Adr = '0, WriteData = '0, ReadData;
    logic        MemRead = 1'b0, MemWrite = 1'b0, ErrClear = 1'b0;
    logic        Stall, MisalignErr, TimeoutErr;
    int          checks = 0, errors = 0;

    mem_handshake_bridge_if bus();

    mem_handshake_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ErrClear(ErrClear),
        .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
        .TimeoutErr(TimeoutErr), .mem(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds the strobes like the controller until Stall drops; acts as the memory,
    // answering in the lat-th request cycle and throwing stray ready pulses elsewhere.
    task automatic do_access(input vec_t v);
        int stall_n = 0, req_n = 0, bus_bad = 0;
        bit done = 0;
        Adr = v.adr; WriteData = v.wdata; MemRead = v.rd; MemWrite = v.wr;
        for (int c = 0; c < TMO + 6 && !done; c++) begin
            @(negedge clk);
            if (Stall) stall_n++; else done = 1;
            if (bus.mem_req) begin
                req_n++;
                if (bus.mem_we !== v.wr || bus.mem_addr !== {v.adr[31:2], 2'b00} ||
                    bus.mem_wdata !== v.wdata) bus_bad++;
            end
            bus.mem_ready = bus.mem_req ? (req_n == v.lat) : 1'($urandom_range(0, 1));
            bus.mem_rdata = (bus.mem_req && req_n == v.lat) ? v.rdata : $urandom;
            if (done) begin
                check("done_rdata", ReadData, v.e_rdata);
                check("done_misalign", 32'(MisalignErr), 32'(v.e_mis));
                check("done_timeout", 32'(TimeoutErr), 32'(v.e_tmo));
            end
            @(posedge clk); #1;
        end
        check("completed", 32'(done), 32'd1);
        check("stall_cycles", 32'(stall_n), 32'(v.e_stall));
        check("req_cycles", 32'(req_n), 32'(v.e_req));
        check("bus_stable", 32'(bus_bad), 32'd0);
        MemRead = 1'b0; MemWrite = 1'b0; ErrClear = v.clr;
        @(negedge clk);
        check("idle_stall", 32'(Stall), 32'd0);
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        ErrClear = 1'b0;
        @(negedge clk);
        check("flag_misalign", 32'(MisalignErr), 32'(v.clr ? 1'b0 : v.e_mis));
        check("flag_timeout", 32'(TimeoutErr), 32'(v.clr ? 1'b0 : v.e_tmo));
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t        tbl [9];
    vec_t        v;
    logic [31:0] rd_m;
    logic        mis_m, tmo_m, mis, to;
    int          op;

    initial begin
        //          adr           wdata         rdata         rd wr clr lat stall req e_rdata       mis tmo
        tbl[0] = '{32'h10,       32'h0,        32'h00500113, 1, 0, 0,  1,  2,  1,  32'h00500113, 0, 0};
        tbl[1] = '{32'h2C,       32'hCAFEF00D, 32'h11111111, 0, 1, 0,  4,  5,  4,  32'h00500113, 0, 0};
        tbl[2] = '{32'h13,       32'h0,        32'h22222222, 1, 0, 1,  1,  1,  0,  32'h0,        1, 0};
        tbl[3] = '{32'h20,       32'h0,        32'h33333333, 1, 0, 1,  99, 5,  4,  ERR,          0, 1};
        tbl[4] = '{32'h40,       32'h12345678, 32'h44444444, 1, 1, 0,  2,  3,  2,  ERR,          0, 0};
        tbl[5] = '{32'h41,       32'h55555555, 32'h0,        0, 1, 0,  1,  1,  0,  32'h0,        1, 0};
        tbl[6] = '{32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 1, 0, 1,  3,  4,  3,  32'h0BADF00D, 1, 0};
        tbl[7] = '{32'h100,      32'h0,        32'hA5A5A5A5, 1, 0, 0,  4,  5,  4,  32'hA5A5A5A5, 0, 0};
        tbl[8] = '{32'h104,      32'h66666666, 32'h0,        0, 1, 0,  5,  5,  4,  32'hA5A5A5A5, 0, 1};
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_misalign", 32'(MisalignErr), 32'd0);
        check("rst_timeout", 32'(TimeoutErr), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) do_access(tbl[i]);

        // ErrClear coinciding with a misalign event: the set wins, the other flag clears
        Adr = 32'h3; MemRead = 1'b1; ErrClear = 1'b1;
        @(negedge clk);
        check("sim_stall_c0", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        ErrClear = 1'b0;
        @(negedge clk);
        check("sim_misalign", 32'(MisalignErr), 32'd1);
        check("sim_timeout", 32'(TimeoutErr), 32'd0);
        check("sim_rdata", ReadData, 32'h0);
        check("sim_stall_done", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0; ErrClear = 1'b1;
        @(posedge clk); #1;
        ErrClear = 1'b0;
        @(negedge clk);
        check("sim_cleared", 32'(MisalignErr), 32'd0);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle, then a stray ready after reset
        do_access(tbl[7]);
        Adr = 32'h80; WriteData = 32'h77; MemWrite = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_busy", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check("mid_req", 32'(bus.mem_req), 32'd0);
        check("mid_we", 32'(bus.mem_we), 32'd0);
        check("mid_addr", bus.mem_addr, 32'h0);
        check("mid_wdata", bus.mem_wdata, 32'h0);
        check("mid_stall", 32'(Stall), 32'd0);
        check("mid_rdata", ReadData, 32'h0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("stray_rdata", ReadData, 32'h0);
        check("stray_req", 32'(bus.mem_req), 32'd0);
        check("stray_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;

        // Randomized accesses against a transaction-level model
        rd_m = '0; mis_m = 1'b0; tmo_m = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.adr = $urandom;
            if ($urandom_range(0, 3) != 0) v.adr[1:0] = 2'b00;
            op = $urandom_range(0, 2);
            v.rd = op != 1; v.wr = op != 0;
            v.wdata = $urandom; v.rdata = $urandom;
            v.clr = $urandom_range(0, 3) == 0;
            v.lat = $urandom_range(1, TMO + 2);
            mis = v.adr[1:0] != 2'b00;
            to = !mis && v.lat > TMO;
            v.e_stall = mis ? 1 : (to ? TMO + 1 : v.lat + 1);
            v.e_req = mis ? 0 : (to ? TMO : v.lat);
            if (mis) rd_m = '0;
            else if (!v.wr) rd_m = to ? ERR : v.rdata;
            mis_m = mis_m | mis; tmo_m = tmo_m | to;
            v.e_rdata = rd_m; v.e_mis = mis_m; v.e_tmo = tmo_m;
            do_access(v);
            if (v.clr) begin mis_m = 1'b0; tmo_m = 1'b0; end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_handshake_bridge.md
# mem_handshake_bridge

Adapter between the multicycle core's single unified memory port and a variable-latency memory using a req/ready handshake. It sits directly downstream of the multicycle controller. It consumes the controller's memory-access strobes and the datapath's address and write data, and drives a `Stall` that freezes the controller FSM and all datapath enables until the access completes. It returns registered read data to the datapath and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles without `mem_ready` before a timeout abort. Legal range is 1..65535.
- `ERR_DATA`, 32'hDEADBEEF: value returned on `ReadData` for a timed-out read.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `Adr` in 32: byte address from the datapath address mux.
- `WriteData` in 32: store data from the datapath.
- `MemRead` in 1: controller requests a read (Fetch, MemRead states).
- `MemWrite` in 1: controller requests a write (MemWrite state).
- `ErrClear` in 1: clears the sticky error flags.
- `ReadData` out 32: registered read result, feeding the IR and data register.
- `Stall` out 1: when high, the controller holds its state and suppresses `PCWrite`, `IRWrite`, `RegWrite` and `MemWrite` effects.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: memory completes the request this cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready` = 1.
- `MisalignErr` out 1: sticky flag, set when `Adr[1:0]` != 0 on an access.
- `TimeoutErr` out 1: sticky flag, set on a timeout abort.

## Operation

**States**
- IDLE, BUSY, DONE.

**IDLE**
- If (`MemRead` | `MemWrite`):
  - `Stall` = 1, combinational, in this same cycle.
  - If `Adr[1:0]` != 0: go to DONE and set `MisalignErr`. No memory request is issued and `ReadData` <= 0.
  - Otherwise: latch `Adr` with bits [1:0] forced to 0, latch `WriteData`, latch `mem_we` = `MemWrite`, clear the timeout counter, and go to BUSY.
- If both `MemRead` and `MemWrite` are high, the access is a write.
- If neither is high: `Stall` = 0 and the block stays in IDLE.

**BUSY**
- `mem_req` = 1 and `Stall` = 1.
- `mem_addr`, `mem_we` and `mem_wdata` come from the latched registers and are stable for the whole request.
- On `mem_ready`:
  - Reads: `ReadData` <= `mem_rdata`.
  - Writes: `ReadData` is unchanged.
  - Go to DONE.
- Otherwise, increment the counter. When the counter reaches `TIMEOUT`:
  - Set `TimeoutErr`.
  - Reads: `ReadData` <= `ERR_DATA`.
  - Go to DONE.
  - `mem_req` drops the next cycle. The memory must tolerate an abandoned request.

**DONE**
- `Stall` = 0 and `mem_req` = 0.
- The controller advances on this edge.
- Always go to IDLE, regardless of the strobes.
- The next access is therefore recognised at the earliest one cycle later. Back-to-back accesses, such as MemWrite then Fetch, each take the full sequence.

**Other rules**
- `mem_ready` is ignored outside BUSY.
- `ReadData` holds its value until the next completed read, timeout or misaligned access.
- `ErrClear` clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Reset mid-access returns to IDLE. `mem_req` is low the cycle after reset is sampled, and a late `mem_ready` is ignored.

## Timing

**Reset values**
- State = IDLE.
- `ReadData` = 0.
- `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `MisalignErr` = 0, `TimeoutErr` = 0.
- Counter = 0.
- `Stall` = 0, because it is decoded from state and strobes.

**Latency**
- Let the access be seen in IDLE at cycle 0, and let `mem_ready` arrive in the k-th BUSY cycle (k ≥ 1).
- `Stall` is high in cycles 0..k.
- DONE is cycle k+1, with `Stall` low and `ReadData` valid.
- Minimum cost is 3 cycles per access: IDLE, BUSY, DONE.
- A misaligned access costs 2 cycles.
- A timeout gives DONE at cycle `TIMEOUT`+1.

**Output types**
- `Stall` is the only combinational output. It is a function of state, `MemRead` and `MemWrite`.
- All other outputs are registered.

## Test plan
1. **Fetch, zero wait.** `MemRead` with `Adr`=0x10; `mem_ready` high in the first BUSY cycle with `mem_rdata`=0x00500113. Required: `Stall` high for 2 cycles; `mem_addr`=0x10, `mem_we`=0; `ReadData`=0x00500113 in DONE; IDLE the next cycle.
2. **Store, 3 waits.** `MemWrite` with `Adr`=0x2C and `WriteData`=0xCAFEF00D; `mem_ready` in BUSY cycle 4. Required: `mem_req`, `mem_we`=1, `mem_addr`=0x2C and `mem_wdata`=0xCAFEF00D stable for 4 cycles; `Stall` high for 5 cycles; `ReadData` unchanged.
3. **Misaligned access.** `MemRead` with `Adr`=0x13. Required: no `mem_req`; DONE at cycle 1; `ReadData`=0; `MisalignErr`=1 until `ErrClear`.
4. **Timeout.** `TIMEOUT`=4; read with `mem_ready` never asserted. Required: `mem_req` high for 4 cycles; `TimeoutErr`=1; `ReadData`=0xDEADBEEF; `Stall` low at cycle 5.
5. **Reset mid-access.** Assert `reset` in BUSY cycle 2, then pulse `mem_ready` one cycle after reset deasserts. Required: IDLE with all outputs at reset values; the stray `mem_ready` is ignored; `ReadData` stays 0.
6. **Simultaneous strobes and error clear.** `MemRead`=`MemWrite`=1 at aligned `Adr`=0x40. Required: `mem_we`=1. Separately, `ErrClear` in the same cycle as a misalign event. Required: `MisalignErr`=1.
